// File: rtl/tt_ternary_pkg.sv
// Shared types and helpers for the ternary matrix-vector sequencer:
// ternary code points, FSM states, 8-bit saturation and ternary multiply.
package tt_ternary_pkg;

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_RSVD = 2'b10;
  localparam logic [1:0] T_NEG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  function automatic logic signed [7:0] sat8(input logic signed [31:0] a);
    if (a > 32'sd127)  return 8'h7F;
    if (a < -32'sd128) return 8'h80;
    return a[7:0];
  endfunction

  // Nine bits so that -(-128) is representable; reserved code decodes as zero.
  function automatic logic signed [8:0] tmul(input logic [1:0] code,
                                             input logic signed [7:0] x);
    case (code)
      T_POS:   return {x[7], x};
      T_NEG:   return -{x[7], x};
      default: return 9'sd0;
    endcase
  endfunction

endpackage

// File: rtl/ternary_mac_lane.sv
// One output accumulator: adds two ternary products per enabled cycle,
// with a synchronous clear that has priority over the enable.
module ternary_mac_lane
  import tt_ternary_pkg::*;
#(
  parameter int ACC_WIDTH = 13
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic [1:0]                  i_w_hi,
  input  logic [1:0]                  i_w_lo,
  input  logic signed [7:0]           i_x_hi,
  input  logic signed [7:0]           i_x_lo,
  output logic signed [ACC_WIDTH-1:0] o_acc
);

  logic signed [8:0]           w_p_hi;
  logic signed [8:0]           w_p_lo;
  logic signed [ACC_WIDTH-1:0] r_acc;

  assign w_p_hi = tmul(i_w_hi, i_x_hi);
  assign w_p_lo = tmul(i_w_lo, i_x_lo);

  always_ff @(posedge clk) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= r_acc + ACC_WIDTH'(w_p_hi) + ACC_WIDTH'(w_p_lo);
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/ternary_mvm_sequencer.sv
// Sequences one ternary y = W^T x job: streams x two elements per beat,
// accumulates into MAX_OUT_LEN lanes, then serialises saturated bytes.
module ternary_mvm_sequencer
  import tt_ternary_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int BIT_WIDTH   = 8,
  parameter int ACC_WIDTH   = BIT_WIDTH + $clog2(MAX_IN_LEN) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [2:0]               cfg_beats,
  input  logic [2:0]               cfg_out_len,
  input  logic                     vec_valid,
  input  logic [2*BIT_WIDTH-1:0]   vec_in,
  output logic [2:0]               w_row_addr,
  input  logic [4*MAX_OUT_LEN-1:0] w_row_data,
  output logic                     busy,
  output logic                     out_valid,
  output logic [BIT_WIDTH-1:0]     out_data,
  output logic                     out_last,
  output logic                     done
);

  state_t                      r_state;
  state_t                      w_next_state;
  logic [2:0]                  r_beat_cnt;
  logic [2:0]                  r_out_idx;
  logic [2:0]                  r_cfg_beats;
  logic [2:0]                  r_cfg_out_len;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic                        r_done;
  logic signed [7:0]           r_out_data;
  logic                        w_clr;
  logic                        w_en;
  logic                        w_last_beat;
  logic                        w_last_out;
  logic signed [ACC_WIDTH-1:0] w_acc [MAX_OUT_LEN];

  assign w_clr       = (r_state == IDLE) && start && !abort;
  assign w_en        = (r_state == ACCUM) && vec_valid && !abort;
  assign w_last_beat = (r_beat_cnt == r_cfg_beats);
  assign w_last_out  = (r_out_idx == r_cfg_out_len);

  for (genvar j = 0; j < MAX_OUT_LEN; j++) begin : g_lane
    ternary_mac_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_en   (w_en),
      .i_w_hi (w_row_data[2*j +: 2]),
      .i_w_lo (w_row_data[2*MAX_OUT_LEN + 2*j +: 2]),
      .i_x_hi (vec_in[2*BIT_WIDTH-1:BIT_WIDTH]),
      .i_x_lo (vec_in[BIT_WIDTH-1:0]),
      .o_acc  (w_acc[j])
    );
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next_state = ACCUM;
        ACCUM:   if (vec_valid && w_last_beat) w_next_state = OUT;
        OUT:     if (w_last_out) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Output strobes default low each cycle; only the OUT state raises them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_beat_cnt    <= '0;
      r_out_idx     <= '0;
      r_cfg_beats   <= '0;
      r_cfg_out_len <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_done        <= 1'b0;
      r_out_data    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      if (!abort) begin
        case (r_state)
          IDLE: if (start) begin
            r_cfg_beats   <= cfg_beats;
            r_cfg_out_len <= cfg_out_len;
            r_beat_cnt    <= '0;
            r_out_idx     <= '0;
          end
          ACCUM: if (vec_valid) begin
            r_beat_cnt <= r_beat_cnt + 3'd1;
            if (w_last_beat) r_out_idx <= '0;
          end
          OUT: begin
            r_out_valid <= 1'b1;
            r_out_data  <= sat8(32'(w_acc[r_out_idx]));
            r_out_last  <= w_last_out;
            r_done      <= w_last_out;
            r_out_idx   <= r_out_idx + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_row_addr = (r_state == ACCUM) ? r_beat_cnt : 3'd0;
  assign busy       = (r_state != IDLE);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign done       = r_done;

endmodule

// File: tb/tb_ternary_mvm_sequencer.sv
// Self-checking bench for ternary_mvm_sequencer against an arithmetic
// reference of y = W^T x with clamping.
module tb_ternary_mvm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  cfg_beats;
  logic [2:0]  cfg_out_len;
  logic        vec_valid;
  logic [15:0] vec_in;
  logic [2:0]  w_row_addr;
  logic [31:0] w_row_data;
  logic        busy;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        done;

  logic [1:0]        tb_w [16][8];
  logic signed [7:0] tb_x [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ternary_mvm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_beats(cfg_beats), .cfg_out_len(cfg_out_len),
    .vec_valid(vec_valid), .vec_in(vec_in),
    .w_row_addr(w_row_addr), .w_row_data(w_row_data),
    .busy(busy), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  // Weight store model: same-cycle read of the addressed row pair.
  always_comb begin
    int a;
    a = 2 * int'(w_row_addr);
    w_row_data = '0;
    for (int j = 0; j < 8; j++) begin
      w_row_data[2*j +: 2]      = tb_w[a][j];
      w_row_data[16 + 2*j +: 2] = tb_w[a+1][j];
    end
  end

  function automatic int dec(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int expect_y(input int j, input int beats);
    int s;
    s = 0;
    for (int i = 0; i < 2*(beats+1); i++) s += dec(tb_w[i][j]) * int'(tb_x[i]);
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic fill_w(input logic [1:0] code);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++) tb_w[i][j] = code;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      tb_x[i] = 8'($urandom);
      for (int j = 0; j < 8; j++) tb_w[i][j] = 2'($urandom_range(3, 0));
    end
  endtask

  // stall: 0 none, n>0 fixed gap of n idle cycles before each beat, -1 random 0..2
  task automatic run_job(input int beats, input int out_len, input int stall, input string name);
    int n;
    logic [7:0] e8;
    @(negedge clk);
    start = 1'b1; cfg_beats = 3'(beats); cfg_out_len = 3'(out_len);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b want 1", name, busy); end
    for (int k = 0; k <= beats; k++) begin
      int st;
      st = (stall >= 0) ? stall : int'($urandom_range(2, 0));
      for (int s = 0; s < st; s++) begin
        vec_valid = 1'b0; vec_in = 16'($urandom);
        checks++;
        if (w_row_addr !== 3'(k)) begin
          errors++; $display("FAIL %s stall_addr got %0d want %0d", name, w_row_addr, k);
        end
        @(negedge clk);
      end
      vec_valid = 1'b1;
      vec_in = {tb_x[2*k], tb_x[2*k+1]};
      checks++;
      if (w_row_addr !== 3'(k)) begin
        errors++; $display("FAIL %s row_addr got %0d want %0d", name, w_row_addr, k);
      end
      @(negedge clk);
    end
    vec_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n <= out_len; c++) begin
      if (out_valid === 1'b1) begin
        e8 = 8'(expect_y(n, beats));
        checks++;
        if (c != n + 1) begin errors++; $display("FAIL %s out_timing idx %0d got cycle %0d want %0d", name, n, c, n+1); end
        checks++;
        if (out_data !== e8) begin
          errors++; $display("FAIL %s out_data[%0d] got %0d want %0d", name, n, $signed(out_data), $signed(e8));
        end
        checks++;
        if (out_last !== (n == out_len) || done !== (n == out_len)) begin
          errors++; $display("FAIL %s last_done[%0d] got %b/%b want %b", name, n, out_last, done, n == out_len);
        end
        n++;
      end
      if (stall < 0) vec_valid = 1'($urandom);
      @(negedge clk);
    end
    vec_valid = 1'b0;
    checks++;
    if (n != out_len + 1) begin errors++; $display("FAIL %s out_count got %0d want %0d", name, n, out_len+1); end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL %s idle_after_job busy %b out_valid %b want 0/0", name, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; vec_valid = 1'b0; vec_in = '0;
    cfg_beats = '0; cfg_out_len = '0;
    fill_w(2'b00);
    for (int i = 0; i < 16; i++) tb_x[i] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_valid, out_last, done} !== 4'b0 || out_data !== 8'h00 || w_row_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset got busy %b ov %b last %b done %b data %h addr %0d want all 0",
               busy, out_valid, out_last, done, out_data, w_row_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic set_identity();
    fill_w(2'b00);
    for (int i = 0; i < 8; i++) tb_w[i][i] = 2'b01;
    for (int i = 0; i < 16; i++) tb_x[i] = (i < 8) ? 8'(i + 1) : 8'sd0;
  endtask

  task automatic test_identity();
    set_identity();
    run_job(3, 3, 0, "identity");
  endtask

  task automatic test_negation();
    fill_w(2'b11);
    for (int j = 0; j < 8; j++) tb_w[1][j] = 2'b10;
    tb_x[0] = 8'sd10; tb_x[1] = -8'sd20;
    run_job(0, 7, 0, "negation");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) tb_x[i] = 8'sd100;
    fill_w(2'b01);
    run_job(7, 7, 0, "sat_pos");
    fill_w(2'b11);
    run_job(7, 7, 0, "sat_neg");
  endtask

  task automatic test_stalls();
    set_identity();
    run_job(3, 3, 3, "stalls");
  endtask

  task automatic test_abort();
    fill_random();
    @(negedge clk);
    start = 1'b1; cfg_beats = 3'd5; cfg_out_len = 3'd7;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vec_valid = 1'b1; vec_in = {tb_x[2*k], tb_x[2*k+1]};
      @(negedge clk);
    end
    abort = 1'b1; vec_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; vec_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL abort_no_done cycle %0d done %b out_valid %b want 0/0", c, done, out_valid);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) tb_x[i] = 8'($urandom);
    run_job(5, 7, 0, "after_abort");
  endtask

  task automatic test_start_abort();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; cfg_beats = 3'd2; cfg_out_len = 3'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_out();
    int seen;
    fill_random();
    @(negedge clk);
    start = 1'b1; cfg_beats = 3'd0; cfg_out_len = 3'd7;
    @(negedge clk);
    start = 1'b0; vec_valid = 1'b1; vec_in = {tb_x[0], tb_x[1]};
    @(negedge clk);
    vec_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 2) begin errors++; $display("FAIL rst_mid_out_seen got %0d want 2", seen); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out busy %b out_valid %b want 0/0", busy, out_valid);
    end
    rst_n = 1'b1;
    run_job(0, 7, 0, "post_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      fill_random();
      run_job(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), -1, $sformatf("random%0d", t));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_identity();
    test_negation();
    test_saturation();
    test_stalls();
    test_abort();
    test_start_abort();
    test_reset_mid_out();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
